vote_capture: RTL

Upstream stage of the 5-input vote display decoder. It collects one yes/no ballot from each of five voters during a voting session and presents the frozen ballot vector on comps[4:0]. The decoder consumes that vector and drives the 7-segment display. Raw switch and button inputs are synchronised and debounced inside the block. A small FSM enforces one ballot per voter per session.

---
 rtl/vote_pkg.sv | 22 ++
 rtl/input_debounce.sv | 56 +++++
 rtl/vote_capture.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/vote_pkg.sv
// Shared definitions for the vote capture block and its debouncer.
// Holds the session state encoding, the voter count that the downstream
// display decoder expects, and the default timing constants.
package vote_pkg;

  // Session states: no session yet, ballots being accepted, result frozen.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPEN   = 2'd1,
    CLOSED = 2'd2
  } vote_state_t;

  // The display decoder is built for exactly five voters.
  localparam int N_VOTERS_DEF        = 5;

  // Stable cycles a synchronised input must hold before the debounced level follows.
  localparam int DEBOUNCE_CYCLES_DEF = 16;

  // Length of a session before the optional timeout closes it.
  localparam int TIMEOUT_CYCLES_DEF  = 1000000;

endpackage

// File: rtl/input_debounce.sv
// Single-bit input conditioner: a 2-FF synchroniser followed by a
// counter-based debouncer with a registered level output.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset (output and counter go to 0)
//   din   raw asynchronous, possibly bouncing input
//   dout  debounced level
//
// The level changes only after the synchronised input has disagreed with
// it for DEBOUNCE_CYCLES consecutive cycles; one agreeing cycle restarts
// the count. With a clean raw edge the output moves 2 + DEBOUNCE_CYCLES
// edges after the raw change.
module input_debounce
  import vote_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  // The counter only runs while the synchronised value disagrees with the
  // current level; reaching DEBOUNCE_CYCLES-1 on a disagreeing cycle means
  // this is the DEBOUNCE_CYCLES-th consecutive one, so the level flips.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      cnt  <= '0;
      dout <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      if (sync != dout) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          dout <= sync;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/vote_capture.sv
// Ballot collection front end for the 5-input vote display decoder.
// Conditions raw voter switches and cast buttons, accepts one ballot per
// voter per session and presents the frozen ballot vector once the
// session closes.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   start         1-cycle pulse, opens a session from IDLE or CLOSED
//   close         1-cycle pulse, closes an open session
//   vote_sw       per-voter yes(1)/no(0) switch, raw
//   cast_btn      per-voter cast button, raw
//   comps         frozen ballot vector (non-voters read as 0)
//   comps_valid   high while comps holds a closed-session result
//   voted         per-voter ballot-recorded flags
//   session_open  high while the session accepts ballots
//
// Optional feature: define VOTE_TIMEOUT_EN to close a session
// automatically TIMEOUT_CYCLES cycles after it opens.
module vote_capture
  import vote_pkg::*;
#(
  parameter int N_VOTERS        = N_VOTERS_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                close,
  input  logic [N_VOTERS-1:0] vote_sw,
  input  logic [N_VOTERS-1:0] cast_btn,
  output logic [N_VOTERS-1:0] comps,
  output logic                comps_valid,
  output logic [N_VOTERS-1:0] voted,
  output logic                session_open
);

  vote_state_t         state;
  logic [N_VOTERS-1:0] sw_db;
  logic [N_VOTERS-1:0] cast_db;
  logic [N_VOTERS-1:0] cast_db_q;
  logic [N_VOTERS-1:0] cast_evt;
  logic [N_VOTERS-1:0] new_cast;
  logic [N_VOTERS-1:0] ballot;
  logic [N_VOTERS-1:0] voted_next;
  logic [N_VOTERS-1:0] ballot_next;
  logic                all_voted;
  logic                timeout_hit;

  for (genvar i = 0; i < N_VOTERS; i++) begin : g_db
    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
      .clk  (clk),
      .rst  (rst),
      .din  (vote_sw[i]),
      .dout (sw_db[i])
    );
    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cast_db (
      .clk  (clk),
      .rst  (rst),
      .din  (cast_btn[i]),
      .dout (cast_db[i])
    );
  end

  // Previous debounced button level for rising-edge detection. Runs in
  // every state so a button held through a start cannot cast on its own.
  always_ff @(posedge clk) begin
    if (rst) begin
      cast_db_q <= '0;
    end else begin
      cast_db_q <= cast_db;
    end
  end

  // Ballot bookkeeping for the current cycle: only first-time casts update
  // the ballot, and the all-voted test includes casts landing this cycle.
  always_comb begin
    cast_evt    = cast_db & ~cast_db_q;
    new_cast    = cast_evt & ~voted;
    voted_next  = voted | cast_evt;
    ballot_next = (ballot & ~new_cast) | (sw_db & new_cast);
    all_voted   = &voted_next;
  end

`ifdef VOTE_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] timer;

  // Counts cycles spent in OPEN; it is zero on the first OPEN cycle
  // because it is held clear in every other state.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if (state != OPEN) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  assign timeout_hit = (state == OPEN) && (timer == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Session FSM. comps is loaded from ballot_next on the closing edge so a
  // cast arriving together with close is part of the frozen result, and
  // non-voters read as 0 because the ballot is cleared when a session opens.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ballot       <= '0;
      voted        <= '0;
      comps        <= '0;
      comps_valid  <= 1'b0;
      session_open <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state        <= OPEN;
            ballot       <= '0;
            voted        <= '0;
            session_open <= 1'b1;
          end
        end
        OPEN: begin
          voted  <= voted_next;
          ballot <= ballot_next;
          if (close || all_voted || timeout_hit) begin
            state        <= CLOSED;
            comps        <= ballot_next;
            comps_valid  <= 1'b1;
            session_open <= 1'b0;
          end
        end
        CLOSED: begin
          if (start) begin
            state        <= OPEN;
            ballot       <= '0;
            voted        <= '0;
            comps        <= '0;
            comps_valid  <= 1'b0;
            session_open <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
